ram_queue_ctrl: RTL and testbench

Circular-buffer controller that drives the team's 384x8 dual-port RAM queue (synchronous write, registered read, 1-cycle read latency) and presents a push/pop byte-FIFO interface to the rest of the embedded system. It owns the write/read pointers, occupancy count and status flags. It also hides the RAM read latency behind a registered pop_valid strobe. The producer (e.g. serial receive path) pushes bytes; the consumer pops them.

---
 rtl/ram_queue_ctrl.sv | 108 ++++++++++
 tb/tb_ram_queue_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_queue_ctrl.sv
// Circular-buffer controller for a dual-port byte RAM with registered read.
// Owns the pointers, occupancy and status flags, and presents a push/pop FIFO.
module ram_queue_ctrl #(
  parameter int ENTRIES    = 384,
  parameter int LOG2       = 9,
  parameter int HIGH_WATER = 320
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [7:0]      push_data,
  input  logic            pop,
  input  logic            flush,
  input  logic            clr_err,
  output logic [7:0]      pop_data,
  output logic            pop_valid,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic [LOG2:0]   count,
  output logic            overflow,
  output logic            underflow,
  output logic            ram_we,
  output logic [LOG2-1:0] ram_waddr,
  output logic [7:0]      ram_wdata,
  output logic [LOG2-1:0] ram_raddr,
  input  logic [7:0]      ram_rdata
);

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   DEPTH     = (LOG2 + 1)'(ENTRIES);
  localparam logic [LOG2:0]   HIGH      = (LOG2 + 1)'(HIGH_WATER);

  logic [LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LOG2:0]   count_reg, count_next;
  logic            pop_valid_reg, pop_valid_next;
  logic            overflow_reg, overflow_next;
  logic            underflow_reg, underflow_next;
  logic            push_ok, pop_ok;

  assign full        = (count_reg == DEPTH);
  assign empty       = (count_reg == '0);
  assign almost_full = (count_reg >= HIGH);
  assign count       = count_reg;

  // Acceptance is judged on the current count only; a simultaneous pop
  // never frees room for a push and a push never feeds a pop.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  assign ram_we    = push_ok;
  assign ram_waddr = wr_ptr_reg;
  assign ram_wdata = push_data;
  assign ram_raddr = rd_ptr_reg;

  assign pop_data  = ram_rdata;
  assign pop_valid = pop_valid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    pop_valid_next = pop_ok;
    // A new error event in the same cycle as clr_err keeps the flag set.
    overflow_next  = (push & full & ~flush) | (overflow_reg & ~clr_err);
    underflow_next = (pop & empty & ~flush) | (underflow_reg & ~clr_err);

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = (wr_ptr_reg == LAST_ADDR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_next = (rd_ptr_reg == LAST_ADDR) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      pop_valid_reg <= pop_valid_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

endmodule

// File: tb/tb_ram_queue_ctrl.sv
// Bench for ram_queue_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ram_queue_ctrl;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
  localparam int HIGH    = 320;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            push, pop, flush, clr_err;
  logic [7:0]      push_data;
  logic [7:0]      pop_data;
  logic            pop_valid, full, empty, almost_full;
  logic [LOG2:0]   count;
  logic            overflow, underflow, ram_we;
  logic [LOG2-1:0] ram_waddr, ram_raddr;
  logic [7:0]      ram_wdata, ram_rdata;

  ram_queue_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2), .HIGH_WATER(HIGH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
    .flush(flush), .clr_err(clr_err), .pop_data(pop_data), .pop_valid(pop_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM: synchronous write, registered read.
  logic [7:0] mem [ENTRIES];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  // Reference model
  logic [7:0] m_q[$];
  int         m_wr, m_rd;
  bit         m_pv, m_ovf, m_unf;
  logic [7:0] m_pdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wr = 0; m_rd = 0; m_pv = 0; m_ovf = 0; m_unf = 0; m_pdata = 8'h00;
  endtask

  task automatic model_edge();
    bit is_full, is_empty, p_ok, q_ok;
    is_full  = (m_q.size() == ENTRIES);
    is_empty = (m_q.size() == 0);
    p_ok = push && !is_full && !flush;
    q_ok = pop && !is_empty && !flush;
    m_ovf = (push && is_full && !flush) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
    m_unf = (pop && is_empty && !flush) ? 1'b1 : (clr_err ? 1'b0 : m_unf);
    if (flush) begin
      m_q.delete();
      m_wr = 0; m_rd = 0; m_pv = 0;
    end else begin
      m_pv = q_ok;
      if (q_ok) begin
        m_pdata = m_q.pop_front();
        m_rd = (m_rd + 1) % ENTRIES;
      end
      if (p_ok) begin
        m_q.push_back(push_data);
        m_wr = (m_wr + 1) % ENTRIES;
      end
    end
  endtask

  task automatic step(input bit p, input logic [7:0] d, input bit po,
                      input bit f, input bit c);
    push = p; push_data = d; pop = po; flush = f; clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 0);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int  n;
      bit  exp_we;
      n = m_q.size();
      exp_we = rst_n && push && !flush && (n != ENTRIES);
      chk("count", int'(count), n);
      chk("full", int'(full), int'(n == ENTRIES));
      chk("empty", int'(empty), int'(n == 0));
      chk("almost_full", int'(almost_full), int'(n >= HIGH));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_unf));
      chk("pop_valid", int'(pop_valid), int'(m_pv));
      chk("ram_we", int'(ram_we), int'(exp_we));
      chk("ram_raddr", int'(ram_raddr), m_rd);
      if (exp_we) begin
        chk("ram_waddr", int'(ram_waddr), m_wr);
        chk("ram_wdata", int'(ram_wdata), int'(push_data));
      end
      if (m_pv) begin
        chk("pop_data", int'(pop_data), int'(m_pdata));
        $display("[TB] pop byte 0x%02h (expected 0x%02h)", pop_data, m_pdata);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    push = 0; pop = 0; flush = 0; clr_err = 0; push_data = 8'h00;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst count", int'(count), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst full", int'(full), 0);
    chk("rst pop_valid", int'(pop_valid), 0);
    rst_n = 1'b1;
    chk_en = 1;

    // Push 1..5 then pop 5 back to back.
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0, 0);
    chk("lit count5", int'(count), 5);
    for (int i = 1; i <= 5; i++) begin
      step(0, 8'h00, 1, 0, 0);
      chk("lit b2b pop_valid", int'(pop_valid), 1);
      chk("lit b2b pop_data", int'(pop_data), i);
    end
    idle();
    chk("lit drained empty", int'(empty), 1);
    chk("lit drained pop_valid", int'(pop_valid), 0);

    // Fill to 384 with i mod 256.
    for (int i = 0; i < ENTRIES; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == HIGH - 2) chk("lit af at 319", int'(almost_full), 0);
      if (i == HIGH - 1) chk("lit af at 320", int'(almost_full), 1);
    end
    chk("lit full", int'(full), 1);
    chk("lit count384", int'(count), ENTRIES);
    step(1, 8'hAA, 0, 0, 0);
    chk("lit overflow", int'(overflow), 1);
    chk("lit count stays", int'(count), ENTRIES);

    // Push+pop while full: pop accepted, push rejected.
    step(1, 8'h77, 1, 0, 0);
    chk("lit fullpp pop_data", int'(pop_data), 8'h00);
    chk("lit fullpp count", int'(count), ENTRIES - 1);
    // Stream through the pointer wrap, then drain.
    for (int i = 0; i < 200; i++) step(1, 8'($urandom_range(0, 255)), 1, 0, 0);
    for (int i = 0; i < ENTRIES - 1; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    chk("lit empty after drain", int'(empty), 1);
    chk("lit ovf cleared", int'(overflow), 0);

    // Empty: push and pop together -> pop rejected.
    step(1, 8'h5A, 1, 0, 0);
    chk("lit underflow", int'(underflow), 1);
    chk("lit count1", int'(count), 1);
    chk("lit no pop_valid", int'(pop_valid), 0);
    step(0, 8'h00, 1, 0, 0);
    chk("lit 5A valid", int'(pop_valid), 1);
    chk("lit 5A data", int'(pop_data), 8'h5A);
    step(0, 8'h00, 0, 0, 1);
    chk("lit unf cleared", int'(underflow), 0);

    // Flush with push and pop asserted.
    for (int i = 0; i < 10; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    push = 1; push_data = 8'hEE; pop = 1; flush = 1; clr_err = 0;
    #1;
    chk("lit flush ram_we", int'(ram_we), 0);
    step(1, 8'hEE, 1, 1, 0);
    chk("lit flush count", int'(count), 0);
    chk("lit flush empty", int'(empty), 1);
    chk("lit flush pop_valid", int'(pop_valid), 0);
    step(1, 8'h33, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("lit 33 data", int'(pop_data), 8'h33);
    chk("lit 33 valid", int'(pop_valid), 1);

    // Async reset mid-stream.
    step(0, 8'h00, 1, 0, 0);  // pop on empty sets underflow
    for (int i = 0; i < 8; i++) step(1, 8'(8'h90 + i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("lit pre-rst count", int'(count), 7);
    chk("lit pre-rst pop_valid", int'(pop_valid), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("lit arst pop_valid", int'(pop_valid), 0);
    chk("lit arst count", int'(count), 0);
    chk("lit arst raddr", int'(ram_raddr), 0);
    chk("lit arst waddr", int'(ram_waddr), 0);
    chk("lit arst underflow", int'(underflow), 0);
    chk("lit arst empty", int'(empty), 1);
    push = 0; pop = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    idle();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
